// File: rtl/cnnip_mem_pkg.sv
// Shared constants and state encoding for the cnnip memory-port reader.
package cnnip_mem_pkg;

    localparam int CNNIP_ADDR_W  = 12;
    localparam int CNNIP_DATA_W  = 32;
    localparam int CNNIP_MAX_LEN = 4096;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } rd_state_e;

endpackage

// File: rtl/cnnip_rd_fifo.sv
// First-word-fall-through FIFO with occupancy count; holds words returning from the BRAM.
module cnnip_rd_fifo #(
    parameter int   DEPTH = 3,
    parameter int   WIDTH = 32,
    localparam int  CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; count/empty gate it, and a reset would block RAM mapping.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/cnnip_mem_reader.sv
// Burst-read initiator for a cnnip_mem_if BRAM port: one read per cycle under
// credit control, data returned as a valid/ready stream with a last marker.
module cnnip_mem_reader
    import cnnip_mem_pkg::*;
#(
    parameter int ADDR_W = CNNIP_ADDR_W,
    parameter int DATA_W = CNNIP_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W:0]   cmd_len,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    localparam int FIFO_DEPTH = RD_LAT + 2;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W      = $clog2(RD_LAT + FIFO_DEPTH + 1);
    localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    rd_state_e         state;
    rd_state_e         state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   last_idx;
    logic [ADDR_W:0]   issue_cnt;
    logic [ADDR_W:0]   beat_cnt;
    logic [RD_LAT-1:0] inflight_sr;
    logic              done_q;

    logic              accept;
    logic              issue;
    logic              done_set;
    logic              credit_ok;
    logic              pop;
    logic [OUT_W-1:0]  inflight_cnt;
    logic [OUT_W-1:0]  outstanding;

    logic [DATA_W-1:0] fifo_dout;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;

    cnnip_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .srst  (srst),
        .push  (inflight_sr[RD_LAT-1]),
        .din   (mem_dout),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign accept    = cmd_ready && cmd_valid;
    assign m_valid   = !fifo_empty;
    assign pop       = m_valid && m_ready;
    assign m_data    = fifo_empty ? '0 : fifo_dout;
    assign m_last    = m_valid && (beat_cnt == last_idx);
    assign done      = done_q;
    assign mem_en    = issue;
    assign mem_we    = 1'b0;
    assign mem_addr  = issue ? addr_q : '0;
    assign mem_din   = '0;

    // NOTE: combinational blocks use blocking (=) so the running sum is read back in the same pass.
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight_cnt = inflight_cnt + OUT_W'(inflight_sr[i]);
        end
    end

    // Words already owed to the FIFO after this cycle's pop; a new read needs a free slot.
    assign outstanding = inflight_cnt + OUT_W'(fifo_count) - OUT_W'(pop);
    assign credit_ok   = (outstanding < OUT_W'(FIFO_DEPTH)) && !(fifo_full && !pop);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        done_set  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        done_set = 1'b1;
                    end else begin
                        state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (issue_cnt == last_idx) begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && m_last) begin
                    done_set  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            last_idx    <= '0;
            issue_cnt   <= '0;
            beat_cnt    <= '0;
            inflight_sr <= '0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            done_q      <= done_set;
            // The bit shifted out of the top is the one pushing mem_dout this cycle.
            inflight_sr <= RD_LAT'({inflight_sr, issue});
            if (accept) begin
                addr_q    <= cmd_base;
                last_idx  <= cmd_len - LEN_ONE;
                issue_cnt <= '0;
                beat_cnt  <= '0;
            end else begin
                if (issue) begin
                    addr_q    <= addr_q + ADDR_ONE;
                    issue_cnt <= issue_cnt + LEN_ONE;
                end
                if (pop) begin
                    beat_cnt <= beat_cnt + LEN_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_cnnip_mem_reader.sv
// Self-checking bench for cnnip_mem_reader: directed vector table, hand-written reset
// sequences and random bursts compared against a behavioural BRAM/stream model.
module tb_cnnip_mem_reader;
    import cnnip_mem_pkg::*;

    localparam int ADDR_W    = CNNIP_ADDR_W;
    localparam int DATA_W    = CNNIP_DATA_W;
    localparam int RD_LAT    = 1;
    localparam int DEPTH     = RD_LAT + 2;
    localparam int MEM_WORDS = 1 << ADDR_W;

    typedef struct {
        string             name;
        logic [ADDR_W-1:0] base;
        int                len;
        logic [3:0]        ready_pat;
        logic [DATA_W-1:0] exp_first;
        logic [DATA_W-1:0] exp_last;
        int                exp_stall;  // 0: gapless issue, 1: credit stall required, 2: either
    } vec_t;

    logic              clk = 1'b0;
    logic              srst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W:0]   cmd_len;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              busy;
    logic              done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cnnip_mem_reader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .srst      (srst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_base  (cmd_base),
        .cmd_len   (cmd_len),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
    );

    // Behavioural BRAM: contents double as the reference for expected stream data.
    logic [DATA_W-1:0] ref_mem [MEM_WORDS];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];

    always @(posedge clk) begin
        if (mem_en && !mem_we) rd_pipe[0] <= ref_mem[mem_addr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_dout = rd_pipe[RD_LAT-1];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic run_burst(input vec_t v, input bit directed);
        logic [ADDR_W-1:0] addr_q [$];
        logic [DATA_W-1:0] data_q [$];
        logic              last_q [$];
        int                done_cyc [$];
        int                first_issue = -1;
        int                first_valid = -1;
        int                first_pop   = -1;
        int                last_pop    = -1;
        bit                credit_ok   = 1'b1;
        bit                stable_ok   = 1'b1;
        bit                port_ok     = 1'b1;
        bit                idle_ok     = 1'b1;
        bit                stall_seen  = 1'b0;
        bit                prev_hold   = 1'b0;
        logic [DATA_W-1:0] prev_data   = '0;
        logic              prev_last   = 1'b0;
        int                addr_err    = 0;
        int                data_err    = 0;
        int                last_err    = 0;
        int                budget      = 4 * v.len + 20;
        int                exp_done;

        @(negedge clk);
        check({v.name, ".cmd_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_base  = v.base;
        cmd_len   = (ADDR_W+1)'(v.len);
        m_ready   = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            m_ready   = v.ready_pat[3 - ((k - 1) % 4)];
            #1;
            if (mem_we !== 1'b0 || mem_din !== '0) port_ok = 1'b0;
            if (prev_hold && (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last))
                stable_ok = 1'b0;
            if (mem_en === 1'b1) begin
                if (first_issue < 0) first_issue = k;
                addr_q.push_back(mem_addr);
            end else if (addr_q.size() > 0 && addr_q.size() < v.len) begin
                stall_seen = 1'b1;
            end
            if (m_valid === 1'b1 && first_valid < 0) first_valid = k;
            if (m_valid === 1'b1 && m_ready) begin
                data_q.push_back(m_data);
                last_q.push_back(m_last);
                if (first_pop < 0) first_pop = k;
                last_pop = k;
            end
            if (addr_q.size() - data_q.size() > DEPTH) credit_ok = 1'b0;
            if (done === 1'b1) done_cyc.push_back(k);
            if (v.len == 0 && cmd_ready !== 1'b1) idle_ok = 1'b0;
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
            if (data_q.size() == v.len && done_cyc.size() > 0 && k >= done_cyc[0] + 2) break;
        end

        check({v.name, ".issue_count"}, addr_q.size(), v.len);
        check({v.name, ".beat_count"}, data_q.size(), v.len);
        for (int i = 0; i < addr_q.size(); i++)
            if (addr_q[i] !== ADDR_W'(int'(v.base) + i)) addr_err++;
        for (int i = 0; i < data_q.size(); i++) begin
            if (data_q[i] !== ref_mem[ADDR_W'(int'(v.base) + i)]) data_err++;
            if (last_q[i] !== (i == v.len - 1)) last_err++;
        end
        check({v.name, ".addr_errors"}, addr_err, 0);
        check({v.name, ".data_errors"}, data_err, 0);
        check({v.name, ".last_errors"}, last_err, 0);
        check({v.name, ".done_pulses"}, done_cyc.size(), 1);
        exp_done = (v.len == 0) ? 1 : last_pop + 1;
        if (done_cyc.size() > 0) check({v.name, ".done_cycle"}, done_cyc[0], exp_done);
        check({v.name, ".credit"}, credit_ok, 1);
        check({v.name, ".hold_stable"}, stable_ok, 1);
        check({v.name, ".we_din_zero"}, port_ok, 1);
        if (v.len == 0) begin
            check({v.name, ".cmd_ready_kept"}, idle_ok, 1);
        end else begin
            check({v.name, ".first_issue_cycle"}, first_issue, 1);
            check({v.name, ".first_valid_cycle"}, first_valid, RD_LAT + 2);
        end
        if (directed && v.len > 0 && data_q.size() == v.len) begin
            check({v.name, ".first_word"}, data_q[0], v.exp_first);
            check({v.name, ".last_word"}, data_q[v.len-1], v.exp_last);
        end
        if (directed && v.exp_stall == 0 && v.len > 0) begin
            check({v.name, ".issue_gapless"}, stall_seen, 0);
            check({v.name, ".beats_back_to_back"}, last_pop - first_pop, v.len - 1);
        end
        if (directed && v.exp_stall == 1) check({v.name, ".credit_stall"}, stall_seen, 1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [5];
        vec_t rv;
        int   got;
        bit   valid_seen;
        bit   done_seen;

        vecs[0] = '{"single",    12'h010, 1, 4'b1111, 32'd1,     32'd1,      0};
        vecs[1] = '{"burst8",    12'h020, 8, 4'b1111, 32'd0,     32'd7,      0};
        vecs[2] = '{"burst8_bp", 12'h020, 8, 4'b1001, 32'd0,     32'd7,      1};
        vecs[3] = '{"wrap",      12'hFFE, 4, 4'b1111, 32'h0FFE,  32'h1001,   0};
        vecs[4] = '{"len0",      12'h100, 0, 4'b1111, 32'd0,     32'd0,      2};

        for (int a = 0; a < MEM_WORDS; a++) ref_mem[a] = $urandom;
        ref_mem[12'h010] = 32'd1;
        ref_mem[12'h100] = 32'd2;
        ref_mem[12'h000] = 32'd3;
        ref_mem[12'h001] = 32'h1001;
        ref_mem[12'hFFE] = 32'h0FFE;
        ref_mem[12'hFFF] = 32'h0FFF;
        for (int i = 0; i < 8; i++) ref_mem[32'h020 + i] = DATA_W'(i);
        for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;

        srst      = 1'b1;
        cmd_valid = 1'b0;
        cmd_base  = '0;
        cmd_len   = '0;
        m_ready   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset.cmd_ready", cmd_ready, 1);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.m_valid", m_valid, 0);
        check("reset.m_data", m_data, 0);
        check("reset.m_last", m_last, 0);
        check("reset.mem_en", mem_en, 0);
        check("reset.mem_addr", mem_addr, 0);
        check("reset.mem_we_din", {mem_we, mem_din}, 0);
        srst = 1'b0;

        for (int i = 0; i < 5; i++) run_burst(vecs[i], 1'b1);

        // srst after three of eight words: in-flight reads dropped, no done.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_base  = 12'h020;
        cmd_len   = 13'd8;
        @(posedge clk);
        got = 0;
        for (int k = 1; k <= 50 && got < 3; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            m_ready   = 1'b1;
            #1;
            if (m_valid && m_ready) got++;
        end
        check("srst.words_before", got, 3);
        srst = 1'b1;
        @(negedge clk);
        #1;
        check("srst.busy", busy, 0);
        check("srst.m_valid", m_valid, 0);
        check("srst.done", done, 0);
        check("srst.cmd_ready", cmd_ready, 1);
        srst       = 1'b0;
        valid_seen = 1'b0;
        done_seen  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            if (m_valid) valid_seen = 1'b1;
            if (done) done_seen = 1'b1;
        end
        check("srst.no_stray_valid", valid_seen, 0);
        check("srst.no_done", done_seen, 0);
        rv = '{"srst_recover", 12'h020, 2, 4'b1111, 32'd0, 32'd1, 0};
        run_burst(rv, 1'b1);

        for (int n = 0; n < 12; n++) begin
            rv.name      = $sformatf("rand%0d", n);
            rv.base      = ADDR_W'($urandom_range(0, MEM_WORDS - 1));
            rv.len       = (n == 5) ? 0 : int'($urandom_range(1, 40));
            rv.ready_pat = 4'($urandom_range(1, 15));
            rv.exp_first = '0;
            rv.exp_last  = '0;
            rv.exp_stall = 2;
            if (rv.len > CNNIP_MAX_LEN) rv.len = CNNIP_MAX_LEN;
            run_burst(rv, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cnnip_mem_reader.md
Name: cnnip_mem_reader

Overview:
- Master-side initiator for the cnnip_mem_if BRAM port exposed by blk_mem_wrapper.
- Accepts a burst-read command (base address, length), issues one read per cycle on the memory port, and returns the data as a valid/ready stream with a last marker.
- Absorbs the fixed BRAM read latency with a credit-controlled FIFO, so downstream back-pressure never drops data.
- Sits between a CNN IP compute/DMA stage and one port (A or B) of blk_mem_wrapper.

Parameters:
- ADDR_W, 12, memory word-address width; matches cnnip_mem_if addr.
- DATA_W, 32, data width; matches cnnip_mem_if din/dout.
- RD_LAT, 1, cycles from mem_en (we=0) to valid mem_dout; legal range 1..3.

Ports:
- clk  in  1  single clock.
- srst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_base  in  ADDR_W  first word address.
- cmd_len  in  ADDR_W+1  word count, 0..4096.
- mem_en  out  1  cnnip_mem_if en.
- mem_we  out  1  cnnip_mem_if we; constant 0.
- mem_addr  out  ADDR_W  cnnip_mem_if addr.
- mem_din  out  DATA_W  cnnip_mem_if din; constant 0.
- mem_dout  in  DATA_W  cnnip_mem_if dout.
- m_valid  out  1  stream data valid.
- m_ready  in  1  stream accept.
- m_data  out  DATA_W  read word.
- m_last  out  1  final word of burst.
- busy  out  1  not IDLE.
- done  out  1  one-cycle pulse at burst completion.

Behaviour:
- Reset: all outputs are 0 except cmd_ready=1. State is IDLE; FIFO, counters and the in-flight pipeline are cleared.
- srst mid-burst: same as reset on the next edge. In-flight reads are discarded, and no done is produced.
- States: IDLE, ISSUE, DRAIN.
- IDLE: cmd_valid&cmd_ready latches base/len.
  - len=0: stay IDLE, pulse done next cycle, issue no reads.
  - Otherwise go to ISSUE.
- ISSUE: mem_en=1 with mem_addr=current address in any cycle where credit allows.
  - Address increments modulo 2^ADDR_W; 0xFFF wraps to 0x000.
  - After the len-th issue, go to DRAIN.
- DRAIN: wait until every word has been handshaked on the stream, then go to IDLE and pulse done in the following cycle.
- In-flight tracking: an RD_LAT-deep shift register of valid bits. The bit exiting the register pushes mem_dout into the FIFO in that cycle.
- FIFO: depth RD_LAT+2, first-word-fall-through.
  - m_valid = FIFO non-empty; m_data = head.
  - Pop on m_valid&m_ready.
- Credit rule: issue only if inflight + fifo_count − pop < RD_LAT+2. This guarantees the FIFO never overflows, with 1 word/cycle sustained throughput when m_ready=1.
- m_last: high with the word whose beat index equals len−1; a beat counter is tracked on pop.
- Latency (RD_LAT=1): command accepted at cycle 0, mem_en at cycle 1, first m_valid at cycle 3.
- m_valid, m_data and m_last hold stable while m_valid&!m_ready.
- A command is not accepted while busy; cmd_ready=0 outside IDLE.

Decomposition:
- Package cnnip_mem_pkg: ADDR_W/DATA_W constants, reader state enum, max-length constant 4096.
- One sub-module: cnnip_rd_fifo, a synchronous FWFT FIFO with parameterised depth and width, push/pop/count/empty/full, and synchronous active-high reset.

Test Plan:
- Preload 0x010=1, 0x100=2, 0x1000→0x000=3 through port A of blk_mem_wrapper. Command base=0x010, len=1 → one mem_en at 0x010; m_data=1 with m_last=1 at cycle 3; done one cycle after the handshake.
- Preload 0x020..0x027 = 0..7. Command len=8 with m_ready=1 → mem_en high 8 consecutive cycles; data 0..7 on 8 consecutive cycles; m_last only on 7.
- Same burst with m_ready toggling 1,0,0,1 → no lost or duplicated words. Assert in the bench that FIFO count never exceeds RD_LAT+2, and mem_en stalls under the credit rule.
- base=0xFFE, len=4 → addresses 0xFFE, 0xFFF, 0x000, 0x001 in order.
- len=0 → no mem_en; done pulses once; cmd_ready stays 1.
- srst asserted after 3 of 8 words delivered → the next cycle shows IDLE, m_valid=0, no done. A new command base=0x020, len=2 then returns 0,1 correctly.
